// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes (a - b) one bit per clock, LSB
// first, using a full-subtractor cell and a registered borrow. A start/busy/
// done handshake frames each operation; the result takes WIDTH cycles.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, an extra 'ovf' output reports signed overflow of a - b.
//   When undefined, the port and its flops are absent.
//
// Parameters:
//   WIDTH  - operand/result width in bits (WIDTH >= 2), default 8
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   start  - request a subtraction, only sampled in IDLE
//   a      - minuend, captured on the edge that accepts start
//   b      - subtrahend, captured together with a
//   busy   - high while bits are being processed (RUN)
//   done   - one-cycle pulse; diff/borrow(/ovf) valid while high
//   diff   - (a - b) mod 2^WIDTH, held until the next accepted start
//   borrow - high iff a < b (unsigned), held like diff
//   ovf    - signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             bw;
    logic [CNT_W-1:0] cnt;

    logic             a0;
    logic             b0;
    logic             d;
    logic             bw_next;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    // A borrow is generated when a0 < b0, and the incoming borrow propagates
    // only when the two operand bits are equal.
    always_comb begin
        a0       = a_sh[0];
        b0       = b_sh[0];
        d        = a0 ^ b0 ^ bw;
        bw_next  = (~a0 & b0) | (~(a0 ^ b0) & bw);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // State register; reset returns to IDLE even in the middle of RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. start is only looked at in IDLE, so a
    // request during RUN or DONE is simply dropped rather than queued.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture in IDLE, one bit per edge in RUN. Each result
    // bit enters diff at the MSB, so after WIDTH shifts the first (LSB) bit
    // has arrived at position 0. The counter stops on the last bit so it never
    // wraps before the hand-off to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        diff  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    diff <= {d, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bw   <= bw_next;
                    if (last_bit) begin
                        borrow <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
                        // Overflow needs differing operand signs and a result
                        // sign that disagrees with the minuend.
                        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results
// come from plain arithmetic on the operands; handshake timing comes from
// edge counts relative to the accepting edge.
// Honours SERIAL_SUB_OVF_EN for the optional ovf output.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it, so both input
    // updates and output sampling happen well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: result defined purely by arithmetic on the operands.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        return W'(x - y);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x < y);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx - sy;
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        check_output({tag, ".diff"}, 32'(diff), 32'(ref_diff(x, y)));
        check_output({tag, ".borrow"}, 32'(borrow), 32'(ref_borrow(x, y)));
`ifdef SERIAL_SUB_OVF_EN
        check_output({tag, ".ovf"}, 32'(ovf), 32'(ref_ovf(x, y)));
`endif
    endtask

    // One full operation from IDLE. pulse_mid re-asserts start (with other
    // operands) on edge E3; pulse_done asserts it during the DONE cycle. Both
    // must be ignored and the result must reflect the E0 operands.
    task automatic apply_stimulus(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input bit pulse_mid, input bit pulse_done);
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        tick();
        start = 1'b0;
        check_output({tag, ".busy_e0"}, 32'(busy), 32'd1);
        check_output({tag, ".done_e0"}, 32'(done), 32'd0);
        for (int e = 1; e <= W; e++) begin
            if (pulse_mid && e == 3) begin
                start = 1'b1;
                a_in  = ~x;
                b_in  = x ^ y;
            end else begin
                start = 1'b0;
            end
            tick();
            if (e < W) begin
                check_output({tag, ".busy_run"}, 32'(busy), 32'd1);
                check_output({tag, ".done_run"}, 32'(done), 32'd0);
            end else begin
                check_output({tag, ".busy_done"}, 32'(busy), 32'd0);
                check_output({tag, ".done_pulse"}, 32'(done), 32'd1);
                check_result(tag, x, y);
            end
        end
        if (pulse_done) begin
            start = 1'b1;
            a_in  = y;
            b_in  = x;
        end
        tick();
        start = 1'b0;
        check_output({tag, ".done_end"}, 32'(done), 32'd0);
        check_output({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check_result({tag, ".hold"}, x, y);
        tick();
        check_output({tag, ".still_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit exp_busy;
        bit exp_done;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.done", 32'(done), 32'd0);
        check_output("reset.diff", 32'(diff), 32'd0);
        check_output("reset.borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_output("reset.ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        $display("[TB] directed operand patterns");
        apply_stimulus("d0A_03", 8'h0A, 8'h03, 1'b0, 1'b0);
        apply_stimulus("d03_0A", 8'h03, 8'h0A, 1'b0, 1'b0);
        apply_stimulus("dFF_FF", 8'hFF, 8'hFF, 1'b0, 1'b0);
        apply_stimulus("d00_01", 8'h00, 8'h01, 1'b0, 1'b0);
        apply_stimulus("d80_01", 8'h80, 8'h01, 1'b0, 1'b0);
        apply_stimulus("d7F_FF", 8'h7F, 8'hFF, 1'b0, 1'b0);
        apply_stimulus("d05_03", 8'h05, 8'h03, 1'b0, 1'b0);

        $display("[TB] start re-pulsed during RUN and DONE");
        apply_stimulus("ignore", 8'h0A, 8'h03, 1'b1, 1'b1);

        $display("[TB] start held high continuously");
        ra    = 8'($urandom_range(0, 255));
        rb    = 8'($urandom_range(0, 255));
        start = 1'b1;
        a_in  = ra;
        b_in  = rb;
        for (int e = 0; e < 20; e++) begin
            tick();
            exp_busy = (e <= 7) || (e >= 10 && e <= 17);
            exp_done = (e == 8) || (e == 18);
            check_output("held.busy", 32'(busy), 32'(exp_busy));
            check_output("held.done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                check_result("held", ra, rb);
            end
        end
        start = 1'b0;
        tick();
        check_output("held.idle", 32'(busy), 32'd0);

        $display("[TB] reset in the middle of RUN");
        apply_stimulus("pre_rst", 8'h03, 8'h0A, 1'b0, 1'b0);
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'h21;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst.busy", 32'(busy), 32'd0);
        check_output("midrst.done", 32'(done), 32'd0);
        check_output("midrst.diff", 32'(diff), 32'd0);
        check_output("midrst.borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_output("midrst.ovf", 32'(ovf), 32'd0);
`endif
        for (int e = 0; e < W + 4; e++) begin
            tick();
            check_output("midrst.no_done", 32'(done), 32'd0);
            check_output("midrst.no_busy", 32'(busy), 32'd0);
        end
        apply_stimulus("post_rst", 8'hC3, 8'h3C, 1'b0, 1'b0);

        $display("[TB] reset and start on the same edge");
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_output("rst_start.busy", 32'(busy), 32'd0);
        tick();
        check_output("rst_start.busy2", 32'(busy), 32'd0);

        $display("[TB] randomized operands");
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            apply_stimulus("rand", ra, rb, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, using a half/full-subtractor cell and a registered borrow. It is the inverse-operation companion to the combinational half adder in the combinational arithmetic library. It gives the sequential datapath a small-area subtract unit with a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is `WIDTH >= 2`.
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `start`, input, 1 bit: request to begin a subtraction. Sampled only in IDLE.
- `a`, input, WIDTH bits: minuend. Captured on the edge that accepts `start`.
- `b`, input, WIDTH bits: subtrahend. Captured on the same edge as `a`.
- `busy`, output, 1 bit: high while bits are being processed (state RUN).
- `done`, output, 1 bit: single-cycle pulse (state DONE); `diff` and `borrow` are valid while it is high.
- `diff`, output, WIDTH bits: `(a - b) mod 2^WIDTH`.
- `borrow`, output, 1 bit: high iff `a < b` (unsigned).
- `ovf`, output, 1 bit: signed overflow. Present only under `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN on a clock edge with `start=1`:
  - load `a` and `b` into shift registers;
  - clear the borrow flop and the bit counter;
  - clear `diff`.
- RUN: on each edge, process bit 0 of both shift registers, with `bw` = borrow flop:
  - `d = a0 ^ b0 ^ bw`
  - `bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw)`
  - shift `d` into the MSB of `diff`, shifting `diff` right;
  - shift both operand registers right;
  - increment the counter.
- RUN → DONE on the edge that processes bit WIDTH-1. On that edge:
  - `borrow` takes the final `bw_next`;
  - `diff` then holds the full result.
- DONE → IDLE unconditionally on the next edge.
- `start` is ignored in RUN and DONE. No queuing; the requester must wait for IDLE.
- `diff` and `borrow` hold their values from DONE through IDLE until the next accepted `start`. During RUN, `diff` is partial and not valid.
- Reset is synchronous and overrides everything, including mid-operation:
  - state returns to IDLE;
  - `busy=0`, `done=0`, `diff=0`, `borrow=0`, `ovf=0`;
  - shift registers and counter clear.
- Width rules:
  - the counter is `$clog2(WIDTH)` bits and must not wrap before the RUN → DONE transition;
  - there are no carry-in or borrow-in ports.

## Timing
- Call the edge that accepts `start` E0. Bits are processed on edges E1..E_WIDTH.
- `busy` is high from after E0 through E_WIDTH (WIDTH cycles).
- `done` is high for exactly one cycle, between E_WIDTH and E_WIDTH+1.
- Latency from the accepting edge to `done` is WIDTH cycles.
- Minimum spacing between accepted starts is WIDTH+2 edges. A `start` held continuously is re-accepted at E_WIDTH+2.
- `start` asserted in the DONE cycle is ignored. If still high in the following IDLE cycle, it is accepted.
- If `rst` and `start` are high on the same edge, `rst` wins.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - `ovf` port exists;
  - the MSBs of `a` and `b` are latched at E0;
  - on E_WIDTH, `ovf <= (a_msb != b_msb) && (d_final != a_msb)`;
  - `ovf` is valid with `done`, holds like `diff`, and reset value is 0.
- Undefined: the `ovf` port and its flops are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, `a=8'h0A`, `b=8'h03`, 1-cycle `start` → `busy` for 8 cycles, `done` 8 edges after E0, `diff=8'h07`, `borrow=0`.
- `a=8'h03`, `b=8'h0A` → `diff=8'hF9`, `borrow=1`. Then `a=b=8'hFF` → `diff=8'h00`, `borrow=0`. Then `a=8'h00`, `b=8'h01` → `diff=8'hFF`, `borrow=1`.
- `start` re-pulsed with new operands at E3 and in the DONE cycle → both ignored; the result is from the E0 operands; the next start is accepted only in IDLE.
- `start` held high continuously → accepted at E0 and E10; `done` pulses at E8 and E18, each for one cycle.
- `rst=1` at E4 mid-RUN → next cycle `busy=0`, `done=0`, `diff=0`, `borrow=0`; `done` never pulses; a new `start` works normally afterwards.
- With `SERIAL_SUB_OVF_EN`: `a=8'h80`, `b=8'h01` → `diff=8'h7F`, `ovf=1`. `a=8'h7F`, `b=8'hFF` → `diff=8'h80`, `ovf=1`. `a=8'h05`, `b=8'h03` → `ovf=0`.
